// File: rtl/bitserial_logic_seq.sv
// bitserial_logic_seq: LSB-first bit-serial bitwise op (zero/xor/and/or) with running compare flag.
// Optional BITSERIAL_LOGIC_SEQ_EARLY_EXIT_EN ends RUN once all remaining operand bits are zero.
module bitserial_logic_seq #(
  parameter int WIDTH = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start_valid,
  output logic             start_ready,
  input  logic [1:0]       op,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             res_valid,
  input  logic             res_ready,
  output logic [WIDTH-1:0] q,
  output logic             flag
);
  localparam int IW = $clog2(WIDTH);
  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;
  state_t state, nstate;
  logic [1:0] opr;
  logic [WIDTH-1:0] sa, sb, qr;
  logic [IW-1:0] idx;
  logic c, ai, bi, qb, acc, last, zero_acc, zero_run;
  assign ai = sa[0];
  assign bi = sb[0];
  assign acc = start_valid && state == IDLE;
`ifdef BITSERIAL_LOGIC_SEQ_EARLY_EXIT_EN
  assign zero_acc = ~|(a | b);
  assign zero_run = ~|((sa | sb) >> 1);
`else
  assign zero_acc = 1'b0;
  assign zero_run = 1'b0;
`endif
  assign last = idx == IW'(WIDTH - 1) || zero_run;
  assign qb = opr == 2'b01 ? ai ^ bi : opr == 2'b10 ? ai & bi : opr == 2'b11 ? ai | bi : 1'b0;
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else state <= nstate;
  end
  always_comb begin
    nstate = state;
    case (state)
      IDLE: nstate = start_valid ? (zero_acc ? DONE : RUN) : IDLE;
      RUN: nstate = last ? DONE : RUN;
      DONE: nstate = res_ready ? IDLE : DONE;
      default: nstate = IDLE;
    endcase
  end
  always_comb begin
    start_ready = state == IDLE;
    res_valid = state == DONE;
    q = state == DONE ? qr : '0;
    flag = state == DONE ? c ^ opr[0] : 1'b0;
  end
  // c tracks "any bit differs" for ops 00/01 and "a wins at the latest differing bit" for 10/11;
  // LSB-first means the last differing bit seen is the most significant one.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      opr <= '0;
      sa <= '0;
      sb <= '0;
      qr <= '0;
      c <= 1'b0;
      idx <= '0;
    end else if (acc) begin
      opr <= op;
      sa <= a;
      sb <= b;
      qr <= '0;
      c <= 1'b0;
      idx <= '0;
    end else if (state == RUN) begin
      qr[idx] <= qb;
      sa <= sa >> 1;
      sb <= sb >> 1;
      c <= opr[1] ? (ai != bi ? ai : c) : c | (ai != bi);
      idx <= last ? '0 : idx + 1'b1;
    end
  end
endmodule

// File: doc/bitserial_logic_seq.md
BITSERIAL_LOGIC_SEQ -- requirements
Module: bitserial_logic_seq

Interface
REQ-001 SHALL have parameter WIDTH, default 16, operand/result width in bits (legal 2..64).
REQ-002 SHALL have port clk  input  1  single clock; all state updates on rising edge.
REQ-003 SHALL have port rst  input  1  reset, asynchronous, active-high.
REQ-004 SHALL have port start_valid  input  1  requester presents an operation.
REQ-005 SHALL have port start_ready  output  1  block can accept an operation.
REQ-006 SHALL have port op  input  2  operation select, sampled on accept.
REQ-007 SHALL have ports a, b  input  WIDTH  operands, sampled on accept.
REQ-008 SHALL have port res_valid  output  1  result available.
REQ-009 SHALL have port res_ready  input  1  consumer takes the result.
REQ-010 SHALL have port q  output  WIDTH  bitwise result.
REQ-011 SHALL have port flag  output  1  compare result.

Function
REQ-012 SHALL implement states IDLE, RUN, DONE; start_ready = (state==IDLE), res_valid = (state==DONE), both decoded from registered state only.
REQ-013 SHALL accept on a rising edge with start_valid & start_ready: latch op, a, b into shift registers; clear q, flag and bit index; go to RUN.
REQ-014 SHALL process one bit per RUN cycle, LSB first, at bit index i = 0..WIDTH-1, writing q[i] from a single-bit logic slice.
REQ-015 SHALL compute q per op: 00 -> 0; 01 -> a^b; 10 -> a&b; 11 -> a|b.
REQ-016 SHALL update internal compare bit c per bit: op 00/01: c <= c | (a_i != b_i); op 10/11: if a_i != b_i then c <= a_i, else c unchanged (unsigned a>b, most significant differing bit decides).
REQ-017 SHALL drive flag = c for op 00 (a!=b) and op 10 (a>b), flag = ~c for op 01 (a==b) and op 11 (a<=b); the inversion is applied in DONE only, and flag = 0 outside DONE.
REQ-018 SHALL move RUN -> DONE on the edge that processes bit WIDTH-1; RUN lasts exactly WIDTH cycles; res_valid rises WIDTH+1 edges after the accept edge.
REQ-019 SHALL hold q, flag and res_valid stable in DONE until res_ready is high on a rising edge, then go to IDLE.
REQ-020 SHALL keep start_ready low in RUN and DONE; start_valid, op, a and b are ignored there; a new accept is possible no earlier than the edge after the result handshake.
REQ-021 SHALL wrap the bit index only via the RUN->DONE transition; the index never exceeds WIDTH-1.
REQ-022 SHALL drive q = 0 in IDLE and RUN; the internal q register is exposed only in DONE.

Reset
REQ-023 SHALL, on rst high at any time including mid-RUN or in DONE, asynchronously force state IDLE, clear q register, c, bit index and operand registers; the in-flight operation is discarded.
REQ-024 SHALL present reset output values start_ready=1, res_valid=0, q=0, flag=0.
REQ-025 SHALL accept a new operation on the first rising edge after rst deasserts if start_valid is high.

Configuration
REQ-026 SHALL, with macro BITSERIAL_LOGIC_SEQ_EARLY_EXIT_EN defined, enter DONE instead of continuing RUN when the not-yet-processed bits of both a and b are all zero; the check is also made at accept, so a=b=0 goes IDLE -> DONE in one edge.
REQ-027 SHALL, with the macro defined, make RUN last (index of highest set bit of a|b)+1 cycles, with q and flag identical to full-length operation.
REQ-028 SHALL, without the macro, always run exactly WIDTH RUN cycles per REQ-018.

Verification
REQ-029 SHALL verify (WIDTH=8) op=10, a=0x5A, b=0x3C -> q=0x18, flag=1, res_valid 9 edges after accept (macro off).
REQ-030 SHALL verify op=01, a=b=0xA5 -> q=0x00, flag=1; then op=00, a=0xA5, b=0xA4 -> q=0x00, flag=1.
REQ-031 SHALL verify op=11, a=0x3C, b=0x5A -> q=0x7E, flag=1 (a<=b); hold res_ready=0 for 5 cycles -> q/flag/res_valid stable, start_ready=0, start_valid pulses ignored.
REQ-032 SHALL verify rst asserted on the 4th RUN cycle -> outputs immediately start_ready=1, res_valid=0, q=0; next op=10, a=0xFF, b=0x0F -> q=0x0F, flag=1.
REQ-033 SHALL verify, with macro on, op=11, a=0x5A, b=0x3C -> 7 RUN cycles, q=0x7E, flag=0; a=b=0 -> res_valid one edge after accept, q=0, flag=1 for op=01.
REQ-034 SHALL verify back-to-back ops with start_valid and res_ready held high -> one accept per WIDTH+2 cycles, no lost or duplicated results.
